gpu_seg_walker: RTL and testbench

- Sequences rectangular VRAM accesses for blit/copy commands by walking rows, then 16-pixel segments within each row.
- Issues one masked segment request per cycle over a req/ack handshake toward the VRAM read arbiter.
- Owns the row/segment counters and the per-segment 16-bit pixel mask: left edge on the first segment, right edge on the last.
- Sits between the command decoder (rectangle setup) and the memory request path.

---
 rtl/gpu_seg_pkg.sv | 18 +
 rtl/gpu_seg_mask.sv | 26 ++
 rtl/gpu_seg_walker.sv | 143 ++++++++++++++
 tb/tb_gpu_seg_walker.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_seg_pkg.sv
// Shared constants, width typedefs and FSM state type for the VRAM segment walker.
package gpu_seg_pkg;

    localparam int unsigned SEG_PIX  = 16;
    localparam int unsigned SEG_BITS = 6;
    localparam int unsigned ROW_BITS = 9;

    typedef logic [SEG_BITS-1:0] seg_t;
    typedef logic [ROW_BITS-1:0] row_t;
    typedef logic [SEG_PIX-1:0]  mask_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_e;

endpackage

// File: rtl/gpu_seg_mask.sv
// Per-segment pixel enable: left-edge clip on the first segment, right-edge clip on the last.
module gpu_seg_mask
    import gpu_seg_pkg::*;
(
    input  logic [3:0] i_x0lo,
    input  logic [3:0] i_right_pos,
    input  logic       i_is_first,
    input  logic       i_is_last,
    output mask_t      o_mask16
);

    mask_t w_left;
    mask_t w_right;

    always_comb begin
        w_left = 16'hFFFF << i_x0lo;
        // rightPos of zero means the rectangle ends exactly on a segment boundary.
        if (i_right_pos == 4'd0) begin
            w_right = 16'hFFFF;
        end else begin
            w_right = 16'hFFFF >> (5'd16 - {1'b0, i_right_pos});
        end
        o_mask16 = (i_is_first ? w_left : 16'hFFFF) & (i_is_last ? w_right : 16'hFFFF);
    end

endmodule

// File: rtl/gpu_seg_walker.sv
// Walks a blit rectangle row by row, issuing one masked 16-pixel segment request per ack.
// Optional field skipping for interlaced targets is enabled by defining GPU_SEG_INTERLACE_EN.
module gpu_seg_walker
    import gpu_seg_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [9:0]  i_x0,
    input  logic [8:0]  i_y0,
    input  logic [10:0] i_w,
    input  logic [9:0]  i_h,
    input  logic        i_abort,
    input  logic        i_ack,
`ifdef GPU_SEG_INTERLACE_EN
    input  logic        i_skipField,
    input  logic        i_field,
`endif
    output logic        o_req,
    output seg_t        o_segX,
    output row_t        o_rowY,
    output mask_t       o_mask16,
    output logic        o_lastSeg,
    output logic        o_busy,
    output logic        o_done
);

    state_e      r_state, w_state_d;
    logic [3:0]  r_x0lo, r_right_pos;
    seg_t        r_seg_base, r_len_hm1, r_seg_idx, w_seg_idx_d;
    row_t        r_y0;
    logic [9:0]  r_h_m1, r_row_idx, w_row_idx_d;
    logic [11:0] w_span_m1;
    logic        w_empty, w_last_seg, w_last_row, w_skip_row, w_req;
    seg_t        w_seg_x;
    row_t        w_row_y;
    mask_t       w_mask;
    logic        unused_bits;

    assign w_span_m1   = {8'd0, i_x0[3:0]} + {1'b0, i_w} - 12'd1;
    assign w_empty     = (i_w == 11'd0) || (i_h == 10'd0);
    assign unused_bits = ^{w_span_m1[11:10], w_span_m1[3:0], r_row_idx[9]};

    assign w_last_seg = (r_seg_idx == r_len_hm1);
    assign w_last_row = (r_row_idx == r_h_m1);
    assign w_seg_x    = r_seg_base + r_seg_idx;
    assign w_row_y    = r_y0 + r_row_idx[ROW_BITS-1:0];

`ifdef GPU_SEG_INTERLACE_EN
    logic r_skip, r_field;

    assign w_skip_row = r_skip && (w_row_y[0] == r_field);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_skip  <= 1'b0;
            r_field <= 1'b0;
        end else if (r_state == IDLE && i_start) begin
            r_skip  <= i_skipField;
            r_field <= i_field;
        end
    end
`else
    assign w_skip_row = 1'b0;
`endif

    assign w_req = (r_state == REQ) && !w_skip_row;

    gpu_seg_mask u_mask (
        .i_x0lo      (r_x0lo),
        .i_right_pos (r_right_pos),
        .i_is_first  (r_seg_idx == '0),
        .i_is_last   (w_last_seg),
        .o_mask16    (w_mask)
    );

    always_comb begin
        w_state_d   = r_state;
        w_seg_idx_d = r_seg_idx;
        w_row_idx_d = r_row_idx;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_d   = w_empty ? DONE : REQ;
                    w_seg_idx_d = '0;
                    w_row_idx_d = '0;
                end
            end
            REQ: begin
                // Abort wins over ack; a coincident ack still counts as accepted.
                if (i_abort) begin
                    w_state_d = DONE;
                end else if (w_skip_row || (i_ack && w_last_seg)) begin
                    if (w_last_row) begin
                        w_state_d = DONE;
                    end else begin
                        w_seg_idx_d = '0;
                        w_row_idx_d = r_row_idx + 10'd1;
                    end
                end else if (i_ack) begin
                    w_seg_idx_d = r_seg_idx + 1'b1;
                end
            end
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_seg_idx   <= '0;
            r_row_idx   <= '0;
            r_x0lo      <= '0;
            r_right_pos <= '0;
            r_seg_base  <= '0;
            r_len_hm1   <= '0;
            r_y0        <= '0;
            r_h_m1      <= '0;
        end else begin
            r_state   <= w_state_d;
            r_seg_idx <= w_seg_idx_d;
            r_row_idx <= w_row_idx_d;
            if (r_state == IDLE && i_start) begin
                r_x0lo      <= i_x0[3:0];
                r_right_pos <= i_x0[3:0] + i_w[3:0];
                r_seg_base  <= i_x0[9:4];
                r_len_hm1   <= w_span_m1[9:4];
                r_y0        <= i_y0;
                r_h_m1      <= i_h - 10'd1;
            end
        end
    end

    assign o_req     = w_req;
    assign o_segX    = w_req ? w_seg_x : '0;
    assign o_rowY    = w_req ? w_row_y : '0;
    assign o_mask16  = w_req ? w_mask : '0;
    assign o_lastSeg = w_req && w_last_seg;
    assign o_busy    = (r_state != IDLE);
    assign o_done    = (r_state == DONE);

endmodule

// File: tb/tb_gpu_seg_walker.sv
// Self-checking bench for gpu_seg_walker: directed table, hand sequences, randomized walks.
module tb_gpu_seg_walker;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_abort, i_ack;
    logic [9:0]  i_x0;
    logic [8:0]  i_y0;
    logic [10:0] i_w;
    logic [9:0]  i_h;
    logic        o_req, o_lastSeg, o_busy, o_done;
    logic [5:0]  o_segX;
    logic [8:0]  o_rowY;
    logic [15:0] o_mask16;

    always #5 clk = ~clk;

    gpu_seg_walker dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_x0      (i_x0),
        .i_y0      (i_y0),
        .i_w       (i_w),
        .i_h       (i_h),
        .i_abort   (i_abort),
        .i_ack     (i_ack),
        .o_req     (o_req),
        .o_segX    (o_segX),
        .o_rowY    (o_rowY),
        .o_mask16  (o_mask16),
        .o_lastSeg (o_lastSeg),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    typedef struct {
        logic [5:0]  segx;
        logic [8:0]  rowy;
        logic [15:0] mask;
        logic        last;
    } req_t;

    typedef struct {
        int x0, y0, w, h;
        int n_req;
        int first_segx, first_rowy, first_mask, last_mask;
    } vec_t;

    req_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   g_n_seen, g_first_segx, g_first_rowy, g_first_mask, g_last_mask;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pixel-level reference: a segment bit is set when its pixel lies inside [x0lo, x0lo+w).
    function automatic void build_model(input int x0, input int y0, input int w, input int h);
        int lo, base, nseg;
        exp_q.delete();
        if (w == 0 || h == 0) return;
        lo   = x0 % 16;
        base = x0 / 16;
        nseg = (lo + w + 15) / 16;
        for (int r = 0; r < h; r++) begin
            for (int s = 0; s < nseg; s++) begin
                req_t e;
                e.mask = '0;
                for (int n = 0; n < 16; n++) begin
                    if (s * 16 + n >= lo && s * 16 + n < lo + w) e.mask[n] = 1'b1;
                end
                e.segx = 6'((base + s) % 64);
                e.rowy = 9'((y0 + r) % 512);
                e.last = (s == nseg - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic run_walk(input int x0, input int y0, input int w, input int h,
                            input int ack_pct, input int hold_at, input int abort_at);
        int   hold_cnt = 0;
        bit   aborted = 1'b0;
        bit   a, ab, req_s;
        req_t e;
        build_model(x0, y0, w, h);
        g_n_seen = 0;
        g_first_segx = -1; g_first_rowy = -1; g_first_mask = -1; g_last_mask = -1;
        i_x0 = 10'(x0); i_y0 = 9'(y0); i_w = 11'(w); i_h = 10'(h); i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (o_done) break;
            req_s = o_req;
            check("busy_during_walk", int'(o_busy), 1);
            check("req_valid", int'(o_req), 1);
            if (o_req) begin
                if (exp_q.size() == 0) begin
                    check("extra_req_pending", exp_q.size(), 1);
                    break;
                end
                e = exp_q[0];
                check("segX", int'(o_segX), int'(e.segx));
                check("rowY", int'(o_rowY), int'(e.rowy));
                check("mask16", int'(o_mask16), int'(e.mask));
                check("lastSeg", int'(o_lastSeg), int'(e.last));
                if (g_n_seen == 0) begin
                    g_first_segx = int'(o_segX);
                    g_first_rowy = int'(o_rowY);
                    g_first_mask = int'(o_mask16);
                end
                g_last_mask = int'(o_mask16);
            end
            if (g_n_seen == hold_at && hold_cnt < 5) begin
                a = 1'b0;
                hold_cnt++;
            end else begin
                a = ($urandom_range(99) < ack_pct);
            end
            ab = (g_n_seen == abort_at);
            // Starts while busy must be ignored.
            if ($urandom_range(7) == 0) begin
                i_start = 1'b1;
                i_x0 = 10'($urandom); i_w = 11'($urandom_range(1, 100)); i_h = 10'($urandom_range(1, 9));
            end
            i_ack = a; i_abort = ab;
            @(posedge clk); #1;
            i_ack = 1'b0; i_abort = 1'b0; i_start = 1'b0;
            if (a && req_s) begin
                void'(exp_q.pop_front());
                g_n_seen++;
            end
            if (ab) begin
                aborted = 1'b1;
                break;
            end
        end
        check("done_pulse", int'(o_done), 1);
        check("done_no_req", int'(o_req), 0);
        if (!aborted) check("missing_reqs", exp_q.size(), 0);
        @(posedge clk); #1;
        check("done_one_cycle", int'(o_done), 0);
        check("idle_not_busy", int'(o_busy), 0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{x0: 5,    y0: 10,  w: 20,   h: 1, n_req: 2,  first_segx: 0,  first_rowy: 10,
                    first_mask: 'hFFE0, last_mask: 'h01FF};
        vecs[1] = '{x0: 16,   y0: 100, w: 16,   h: 3, n_req: 3,  first_segx: 1,  first_rowy: 100,
                    first_mask: 'hFFFF, last_mask: 'hFFFF};
        vecs[2] = '{x0: 3,    y0: 0,   w: 4,    h: 1, n_req: 1,  first_segx: 0,  first_rowy: 0,
                    first_mask: 'h0078, last_mask: 'h0078};
        vecs[3] = '{x0: 1020, y0: 511, w: 8,    h: 2, n_req: 4,  first_segx: 63, first_rowy: 511,
                    first_mask: 'hF000, last_mask: 'h000F};
        vecs[4] = '{x0: 0,    y0: 7,   w: 1024, h: 1, n_req: 64, first_segx: 0,  first_rowy: 7,
                    first_mask: 'hFFFF, last_mask: 'hFFFF};
        vecs[5] = '{x0: 7,    y0: 3,   w: 9,    h: 2, n_req: 2,  first_segx: 0,  first_rowy: 3,
                    first_mask: 'hFF80, last_mask: 'hFF80};
        vecs[6] = '{x0: 40,   y0: 9,   w: 0,    h: 5, n_req: 0,  first_segx: 0,  first_rowy: 0,
                    first_mask: 0, last_mask: 0};

        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ack = 1'b0;
        i_x0 = '0; i_y0 = '0; i_w = '0; i_h = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", int'(o_req), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_lastSeg", int'(o_lastSeg), 0);
        check("rst_segX", int'(o_segX), 0);
        check("rst_rowY", int'(o_rowY), 0);
        check("rst_mask", int'(o_mask16), 0);
        i_rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_walk(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, 100, -1, -1);
            check("vec_req_count", g_n_seen, vecs[i].n_req);
            if (vecs[i].n_req > 0) begin
                check("vec_first_segX", g_first_segx, vecs[i].first_segx);
                check("vec_first_rowY", g_first_rowy, vecs[i].first_rowy);
                check("vec_first_mask", g_first_mask, vecs[i].first_mask);
                check("vec_last_mask", g_last_mask, vecs[i].last_mask);
            end
        end

        // Ack withheld 5 cycles on the 2nd segment of a 3-segment row.
        run_walk(0, 20, 48, 1, 100, 1, -1);
        check("hold_req_count", g_n_seen, 3);

        // Abort during the 2nd request of a 4x4-segment walk, with ack in the same cycle.
        run_walk(0, 0, 64, 4, 100, -1, 1);
        check("abort_req_count", g_n_seen, 2);

        // Reset mid-walk drops the request without a done pulse.
        i_x0 = 10'd0; i_y0 = 9'd0; i_w = 11'd64; i_h = 10'd4; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("prerst_req", int'(o_req), 1);
        i_rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_req", int'(o_req), 0);
        check("midrst_busy", int'(o_busy), 0);
        check("midrst_done", int'(o_done), 0);
        i_rst = 1'b0;
        @(posedge clk); #1;
        check("postrst_done", int'(o_done), 0);

        // Abort in IDLE is ignored.
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        check("idle_abort_busy", int'(o_busy), 0);
        check("idle_abort_done", int'(o_done), 0);

        // Start and abort together in IDLE: start wins.
        i_x0 = 10'd3; i_y0 = 9'd44; i_w = 11'd4; i_h = 10'd1; i_start = 1'b1; i_abort = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_abort = 1'b0;
        check("startabort_req", int'(o_req), 1);
        check("startabort_mask", int'(o_mask16), 'h0078);
        check("startabort_rowY", int'(o_rowY), 44);
        i_ack = 1'b1;
        @(posedge clk); #1;
        i_ack = 1'b0;
        check("startabort_done", int'(o_done), 1);
        @(posedge clk); #1;

        for (int t = 0; t < 25; t++) begin
            int x0, lo, w, h, y0, abort_at;
            x0 = $urandom_range(1023);
            lo = x0 % 16;
            if ($urandom_range(3) == 0) w = $urandom_range(1024 - lo);
            else w = $urandom_range(60, 1);
            h = $urandom_range(5);
            y0 = $urandom_range(511);
            abort_at = ($urandom_range(3) == 0) ? $urandom_range(10) : -1;
            run_walk(x0, y0, w, h, $urandom_range(100, 20), $urandom_range(5), abort_at);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
